// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter.
// Port identifiers and the default starvation limit.
package arm32_base;

    localparam logic [1:0] PORT_NONE = 2'd0;
    localparam logic [1:0] PORT_CPU  = 2'd1;
    localparam logic [1:0] PORT_DBG  = 2'd2;

    localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating count of consecutive contests lost by the debug port.
// Clear has priority over increment; reset has priority over both.
module arb_wait_counter
    import arm32_base::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_WAIT);

    // Count lost contests, holding at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAXV) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: CPU has priority, debug port has a
// starvation guard and takes the port exclusively while halted.
module mem_port_arbiter
    import arm32_base::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [3:0]  c_we,
    input  logic        c_re,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_stall,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic        d_re,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        d_halt,
    output logic [31:0] mem_addr,
    output logic        mem_do_read,
    output logic [3:0]  mem_do_write_byte,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        proto_err
);

    logic [1:0]       sel;
    logic             cpu_elig;
    logic             dbg_win;
    logic [CNT_W-1:0] wait_cnt;
    logic             at_max;
    logic             a_re;
    logic [3:0]       a_we;
    logic             bad;
    logic             c_rv_q;
    logic             d_rv_q;
    logic             err_q;

    assign cpu_elig = c_req & ~d_halt;
    assign dbg_win  = d_req & (~cpu_elig | at_max | d_halt);

    // Pick this cycle's winner; nobody wins while in reset.
    always_comb begin
        sel = PORT_NONE;
        if (!reset) begin
            if (dbg_win) begin
                sel = PORT_DBG;
            end else if (cpu_elig) begin
                sel = PORT_CPU;
            end
        end
    end

    assign c_gnt   = (sel == PORT_CPU);
    assign d_gnt   = (sel == PORT_DBG);
    assign c_stall = c_req & ~c_gnt & ~reset;

    // Route the winner's access fields to the memory port.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        a_we           = '0;
        a_re           = 1'b0;
        case (sel)
            PORT_CPU: begin
                mem_addr       = c_addr;
                mem_write_data = c_wdata;
                a_we           = c_we;
                a_re           = c_re;
            end
            PORT_DBG: begin
                mem_addr       = d_addr;
                mem_write_data = d_wdata;
                a_we           = d_we;
                a_re           = d_re;
            end
            default: ;
        endcase
    end

    // A read that also writes is issued as a write only.
    assign mem_do_write_byte = a_we;
    assign mem_do_read       = a_re & (a_we == 4'h0);
    assign bad               = a_re & (a_we != 4'h0);

    // Track which port owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            c_rv_q <= c_gnt & mem_do_read;
            d_rv_q <= d_gnt & mem_do_read;
            err_q  <= err_q | bad;
        end
    end

    assign c_rvalid  = c_rv_q & ~reset;
    assign d_rvalid  = d_rv_q & ~reset;
    assign c_rdata   = c_rvalid ? mem_read_data : '0;
    assign d_rdata   = d_rvalid ? mem_read_data : '0;
    assign proto_err = err_q & ~reset;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .inc    (d_req & ~d_gnt),
        .clr    (~d_req | d_gnt),
        .cnt    (wait_cnt),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Read returns are queued at grant time and matched on rvalid.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_re, c_gnt, c_stall, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_we;
    logic        d_req, d_re, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_we;
    logic        d_halt;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = 32'hBAD0_BAD0;
    logic        mem_do_read;
    logic [3:0]  mem_do_write_byte;
    logic        proto_err;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t cq[$];
    exp_t dq[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .c_req             (c_req),
        .c_addr            (c_addr),
        .c_we              (c_we),
        .c_re              (c_re),
        .c_wdata           (c_wdata),
        .c_gnt             (c_gnt),
        .c_stall           (c_stall),
        .c_rvalid          (c_rvalid),
        .c_rdata           (c_rdata),
        .d_req             (d_req),
        .d_addr            (d_addr),
        .d_we              (d_we),
        .d_re              (d_re),
        .d_wdata           (d_wdata),
        .d_gnt             (d_gnt),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata),
        .d_halt            (d_halt),
        .mem_addr          (mem_addr),
        .mem_do_read       (mem_do_read),
        .mem_do_write_byte (mem_do_write_byte),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .proto_err         (proto_err)
    );

    function automatic logic [31:0] mdat(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: one-cycle registered read, junk when idle.
    always @(posedge clk) begin
        mem_read_data <= mem_do_read ? mdat(mem_addr) : 32'hBAD0_BAD0;
        cyc_n <= cyc_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Match read returns against the queued expectations.
    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].due == cyc_n) begin
            chk("c_rvalid", 32'(c_rvalid), 1);
            chk("c_rdata", c_rdata, cq[0].data);
            void'(cq.pop_front());
        end else begin
            chk("c_rv_idle", 32'(c_rvalid), 0);
            chk("c_rd_idle", c_rdata, 0);
        end
        if (dq.size() > 0 && dq[0].due == cyc_n) begin
            chk("d_rvalid", 32'(d_rvalid), 1);
            chk("d_rdata", d_rdata, dq[0].data);
            void'(dq.pop_front());
        end else begin
            chk("d_rv_idle", 32'(d_rvalid), 0);
            chk("d_rd_idle", d_rdata, 0);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        c_req = 0; c_re = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_halt = 0;
    endtask

    task automatic c_rd(input logic [31:0] a);
        c_req = 1; c_re = 1; c_we = 0; c_addr = a;
    endtask

    task automatic push_c(input logic [31:0] a);
        exp_t e;
        e.due = cyc_n + 1;
        e.data = mdat(a);
        cq.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] a);
        exp_t e;
        e.due = cyc_n + 1;
        e.data = mdat(a);
        dq.push_back(e);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cgnt"}, 32'(c_gnt), 0);
        chk({tag, "_dgnt"}, 32'(d_gnt), 0);
        chk({tag, "_stall"}, 32'(c_stall), 0);
        chk({tag, "_rd"}, 32'(mem_do_read), 0);
        chk({tag, "_wb"}, 32'(mem_do_write_byte), 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdat"}, mem_write_data, 0);
        chk({tag, "_err"}, 32'(proto_err), 0);
    endtask

    initial begin
        idle();
        reset = 1;
        nxt();
        nxt();
        c_rd(32'h44);
        d_req = 1; d_re = 1;
        #1;
        chk_quiet("rst");

        // 1: single CPU read
        nxt();
        reset = 0;
        idle();
        c_rd(32'h100);
        #1;
        chk("t1_cgnt", 32'(c_gnt), 1);
        chk("t1_stall", 32'(c_stall), 0);
        chk("t1_rd", 32'(mem_do_read), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_dgnt", 32'(d_gnt), 0);
        push_c(32'h100);
        nxt();
        idle();

        // 2: starvation guard
        nxt();
        c_req = 1; c_we = 4'hF; c_addr = 32'h200; c_wdata = 32'h11;
        d_req = 1; d_we = 4'h1; d_addr = 32'h300; d_wdata = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_cgnt", 32'(c_gnt), 1);
            chk("t2_dgnt", 32'(d_gnt), 0);
            chk("t2_cnt", 32'(dut.wait_cnt), 32'(i));
            nxt();
        end
        #1;
        chk("t2_dwin", 32'(d_gnt), 1);
        chk("t2_clost", 32'(c_gnt), 0);
        chk("t2_cstall", 32'(c_stall), 1);
        chk("t2_dwb", 32'(mem_do_write_byte), 32'h1);
        chk("t2_daddr", mem_addr, 32'h300);
        chk("t2_cnt4", 32'(dut.wait_cnt), 4);
        nxt();
        #1;
        chk("t2_cback", 32'(c_gnt), 1);
        chk("t2_cnt0", 32'(dut.wait_cnt), 0);
        nxt();
        idle();

        // 3: halt blocks CPU write, release grants same cycle
        d_halt = 1;
        c_req = 1; c_we = 4'b0011; c_wdata = 32'h1234; c_addr = 32'h60;
        #1;
        chk("t3_cgnt", 32'(c_gnt), 0);
        chk("t3_stall", 32'(c_stall), 1);
        chk("t3_wb", 32'(mem_do_write_byte), 0);
        nxt();
        #1;
        chk("t3_stall2", 32'(c_stall), 1);
        nxt();
        d_halt = 0;
        #1;
        chk("t3_cgnt2", 32'(c_gnt), 1);
        chk("t3_wb2", 32'(mem_do_write_byte), 32'h3);
        chk("t3_wdat", mem_write_data, 32'h1234);
        nxt();
        idle();

        // 3b: halt while a CPU read is in flight
        c_rd(32'h40);
        #1;
        chk("t3b_cgnt", 32'(c_gnt), 1);
        push_c(32'h40);
        nxt();
        d_halt = 1;
        c_rd(32'h48);
        d_req = 1; d_re = 1; d_addr = 32'h50;
        #1;
        chk("t3b_cblk", 32'(c_gnt), 0);
        chk("t3b_stall", 32'(c_stall), 1);
        chk("t3b_dgnt", 32'(d_gnt), 1);
        push_d(32'h50);
        nxt();
        idle();

        // 4: back-to-back reads from both ports
        c_rd(32'h10);
        #1;
        chk("t4_cgnt", 32'(c_gnt), 1);
        push_c(32'h10);
        nxt();
        idle();
        d_req = 1; d_re = 1; d_addr = 32'h20;
        #1;
        chk("t4_dgnt", 32'(d_gnt), 1);
        chk("t4_addr", mem_addr, 32'h20);
        push_d(32'h20);
        nxt();
        idle();
        nxt();

        // 5: reset drops an in-flight read
        c_rd(32'h80);
        d_req = 1; d_re = 1; d_addr = 32'h90;
        #1;
        chk("t5_cgnt", 32'(c_gnt), 1);
        nxt();
        reset = 1;
        #1;
        chk_quiet("t5");
        nxt();
        reset = 0;
        idle();
        #1;
        chk("t5_cnt", 32'(dut.wait_cnt), 0);
        nxt();

        // 6: read+write on debug port is a write and sets proto_err
        d_req = 1; d_re = 1; d_we = 4'hF;
        d_addr = 32'h500; d_wdata = 32'hCAFE;
        #1;
        chk("t6_dgnt", 32'(d_gnt), 1);
        chk("t6_rd", 32'(mem_do_read), 0);
        chk("t6_wb", 32'(mem_do_write_byte), 32'hF);
        chk("t6_err0", 32'(proto_err), 0);
        nxt();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_err", 32'(proto_err), 1);
            nxt();
        end
        reset = 1;
        nxt();
        reset = 0;
        #1;
        chk("t6_clr", 32'(proto_err), 0);
        nxt();
        nxt();
        chk("cq_empty", 32'(cq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
